// File: rtl/bk_adder_arbiter_if.sv
// Request / adder / response bundle for bk_adder_arbiter.
// rsp_ovf is present only when BK_ARB_OVF_EN is defined.
interface bk_adder_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(NREQ);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid,
  // once raised, stays high with stable payload until that edge.
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic                  add_cin;
  logic [WIDTH-1:0]      add_sum;
  logic                  add_cout;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
`ifdef BK_ARB_OVF_EN
  logic                  rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );
  modport slave (
    input  req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
  modport slave (
    input  req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
`endif
endinterface

// File: rtl/bk_adder_arbiter.sv
// Round-robin arbiter sharing one external adder among NREQ requesters, one op in flight.
// Optional signed-overflow flag on the response when BK_ARB_OVF_EN is defined.
module bk_adder_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  bk_adder_arbiter_if.slave bus,
  output logic [1:0]        dbg_state_o
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rr_ptr_d;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             rsp_valid_q;
`ifdef BK_ARB_OVF_EN
  logic             ovf_q;
`endif

  logic [NREQ-1:0]  hi_mask;
  logic [NREQ-1:0]  hi_req;
  logic [NREQ-1:0]  pick_vec;
  logic [NREQ-1:0]  grant_oh;
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_cin;

  // Requests at or above rr_ptr win first; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      hi_mask[i] = (IDW'(i) >= rr_ptr_q);
    end
    hi_req    = bus.req_valid & hi_mask;
    pick_vec  = (|hi_req) ? hi_req : bus.req_valid;
    grant_any = |bus.req_valid;
    grant_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pick_vec[i]) grant_idx = IDW'(i);
    end

    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a   = bus.req_a[i*WIDTH +: WIDTH];
        sel_b   = bus.req_b[i*WIDTH +: WIDTH];
        sel_cin = bus.req_cin[i];
      end
    end

    rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

    // Ready is suppressed while rst is high so no requester believes it was accepted.
    grant_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_oh[i] = !rst && (state_q == IDLE) && grant_any && (grant_idx == IDW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      rsp_id_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef BK_ARB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            a_q      <= sel_a;
            b_q      <= sel_b;
            cin_q    <= sel_cin;
            id_q     <= grant_idx;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          sum_q       <= bus.add_sum;
          cout_q      <= bus.add_cout;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
`ifdef BK_ARB_OVF_EN
          ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (bus.add_sum[WIDTH-1] != a_q[WIDTH-1]);
`endif
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = grant_oh;
  assign bus.add_a     = a_q;
  assign bus.add_b     = b_q;
  assign bus.add_cin   = cin_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
`ifdef BK_ARB_OVF_EN
  assign bus.rsp_ovf   = ovf_q;
`endif
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_bk_adder_arbiter.sv
// Directed scenarios plus randomized traffic for bk_adder_arbiter, checked against
// a queue-based reference of arbitration order and a+b+cin arithmetic.
module tb_bk_adder_arbiter;
  localparam int NREQ   = 4;
  localparam int WIDTH  = 8;
  localparam int IDW    = $clog2(NREQ);
  localparam int RW     = IDW + 2 + WIDTH;
  localparam int N_OPS  = 10000;
  localparam int BUDGET = 80000;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_cmp = 0;
  int         n_err = 0;

  bk_adder_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  bk_adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // External adder stand-in: plain arithmetic on the registered operands.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b}
                                       + {{WIDTH{1'b0}}, bus.add_cin};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rsp_obs();
`ifdef BK_ARB_OVF_EN
    return {bus.rsp_id, bus.rsp_ovf, bus.rsp_cout, bus.rsp_sum};
`else
    return {bus.rsp_id, 1'b0, bus.rsp_cout, bus.rsp_sum};
`endif
  endfunction

  // Reference result {id, ovf, cout, sum} from integer arithmetic.
  function automatic logic [RW-1:0] ref_rsp(input int id, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b, input logic c);
    int unsigned      full;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
    full = int'(a) + int'(b) + (c ? 1 : 0);
    s    = full[WIDTH-1:0];
    co   = full[WIDTH];
    ov   = 1'b0;
`ifdef BK_ARB_OVF_EN
    ov   = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
`endif
    return {IDW'(id), ov, co, s};
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
    bus.req_cin[i]              = c;
  endtask

  task automatic single_op(input string tag, input int id, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic c);
    set_req(id, a, b, c);
    bus.req_valid = onehot(id);
    bus.rsp_ready = 1'b1;
    #1;
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'(onehot(id)));
    cyc();
    bus.req_valid = '0;
    #1;
    chk({tag, "_add_a"}, 32'(bus.add_a), 32'(a));
    chk({tag, "_add_b"}, 32'(bus.add_b), 32'(b));
    chk({tag, "_add_cin"}, 32'(bus.add_cin), 32'(c));
    chk({tag, "_exec_rv"}, 32'(bus.rsp_valid), 0);
    cyc();
    chk({tag, "_rv"}, 32'(bus.rsp_valid), 1);
    chk({tag, "_rsp"}, 32'(rsp_obs()), 32'(ref_rsp(id, a, b, c)));
    cyc();
    chk({tag, "_rv_clr"}, 32'(bus.rsp_valid), 0);
  endtask

  // ---------------- scenario sequence ----------------
  initial begin
    logic [WIDTH-1:0] ta [NREQ];
    logic [WIDTH-1:0] tb_b [NREQ];
    logic             tc [NREQ];
    logic [RW-1:0]    hold_exp;
    logic [NREQ-1:0]  pend;
    logic [WIDTH-1:0] ra [NREQ];
    logic [WIDTH-1:0] rb [NREQ];
    logic             rc [NREQ];
    int               waits [NREQ];
    logic [RW-1:0]    exp_q [$];
    int               rr, g, accepted, served, acc_cyc, cyc_n;
    logic             busy, prev_hold;

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp", 32'(rsp_obs()), 0);
    chk("rst_add_a", 32'(bus.add_a), 0);
    chk("rst_add_b", 32'(bus.add_b), 0);
    chk("rst_add_cin", 32'(bus.add_cin), 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    cyc();

    // T1 single op, signed overflow case
    single_op("t1", 0, 8'h3C, 8'h45, 1'b0);
    // T2 wrap-around
    single_op("t2", 2, 8'hFF, 8'h00, 1'b1);

    // T3 round robin with all requesters held valid
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      ta[i]   = WIDTH'($urandom);
      tb_b[i] = WIDTH'($urandom);
      tc[i]   = 1'($urandom);
      set_req(i, ta[i], tb_b[i], tc[i]);
    end
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_ready", 32'(bus.req_ready), 32'(onehot(k % NREQ)));
      chk("t3_idle_rv", 32'(bus.rsp_valid), 0);
      cyc();
      chk("t3_exec_rv", 32'(bus.rsp_valid), 0);
      chk("t3_exec_ready", 32'(bus.req_ready), 0);
      cyc();
      chk("t3_rv", 32'(bus.rsp_valid), 1);
      chk("t3_rsp", 32'(rsp_obs()), 32'(ref_rsp(k % NREQ, ta[k % NREQ], tb_b[k % NREQ], tc[k % NREQ])));
      cyc();
    end
    bus.req_valid = '0;

    // T4 backpressure while other requesters wait
    ta[3] = WIDTH'($urandom); tb_b[3] = WIDTH'($urandom); tc[3] = 1'($urandom);
    set_req(3, ta[3], tb_b[3], tc[3]);
    bus.req_valid = 4'b1000;
    bus.rsp_ready = 1'b0;
    #1;
    chk("t4_ready", 32'(bus.req_ready), 32'(4'b1000));
    cyc();
    bus.req_valid = 4'b0111;
    #1;
    chk("t4_exec_ready", 32'(bus.req_ready), 0);
    cyc();
    hold_exp = ref_rsp(3, ta[3], tb_b[3], tc[3]);
    chk("t4_rv", 32'(bus.rsp_valid), 1);
    chk("t4_rsp", 32'(rsp_obs()), 32'(hold_exp));
    for (int h = 0; h < 5; h++) begin
      cyc();
      chk("t4_hold_rv", 32'(bus.rsp_valid), 1);
      chk("t4_hold_rsp", 32'(rsp_obs()), 32'(hold_exp));
      chk("t4_hold_ready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    cyc();
    chk("t4_rv_clr", 32'(bus.rsp_valid), 0);
    bus.req_valid = '0;

    // T5 asynchronous reset while the op is executing
    ta[1] = WIDTH'($urandom_range(1, 255)); tb_b[1] = WIDTH'($urandom_range(1, 255)); tc[1] = 1'b1;
    set_req(1, ta[1], tb_b[1], tc[1]);
    bus.req_valid = 4'b0010;
    #1;
    chk("t5_ready", 32'(bus.req_ready), 32'(4'b0010));
    cyc();
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_add_a", 32'(bus.add_a), 0);
    chk("t5_rst_add_b", 32'(bus.add_b), 0);
    chk("t5_rst_add_cin", 32'(bus.add_cin), 0);
    chk("t5_rst_rv", 32'(bus.rsp_valid), 0);
    chk("t5_rst_rsp", 32'(rsp_obs()), 0);
    chk("t5_rst_ready", 32'(bus.req_ready), 0);
    cyc();
    #2 rst = 1'b0;
    #1;
    chk("t5_rearb_ready", 32'(bus.req_ready), 32'(4'b0010));
    cyc();
    bus.req_valid = '0;
    cyc();
    chk("t5_rv", 32'(bus.rsp_valid), 1);
    chk("t5_rsp", 32'(rsp_obs()), 32'(ref_rsp(1, ta[1], tb_b[1], tc[1])));
    cyc();
    chk("t5_rv_clr", 32'(bus.rsp_valid), 0);

    // T6 randomized traffic against the reference model
    do_reset();
    pend      = '0;
    rr        = 0;
    busy      = 1'b0;
    prev_hold = 1'b0;
    accepted  = 0;
    served    = 0;
    acc_cyc   = -10;
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
    for (cyc_n = 0; cyc_n < BUDGET; cyc_n++) begin
      if (accepted >= N_OPS && pend == '0 && !busy) break;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && accepted < N_OPS && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          ra[i]   = WIDTH'($urandom);
          rb[i]   = WIDTH'($urandom);
          rc[i]   = 1'($urandom);
          set_req(i, ra[i], rb[i], rc[i]);
        end
      end
      bus.req_valid = pend;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (!busy && pend != '0) begin
        g = rr_pick(pend, rr);
        chk("rnd_grant", 32'(bus.req_ready), 32'(onehot(g)));
        chk("rnd_fair", 32'(waits[g] < NREQ), 1);
        for (int j = 0; j < NREQ; j++) if (j != g && pend[j]) waits[j]++;
        waits[g] = 0;
        exp_q.push_back(ref_rsp(g, ra[g], rb[g], rc[g]));
        pend[g]  = 1'b0;
        rr       = (g + 1) % NREQ;
        busy     = 1'b1;
        acc_cyc  = cyc_n;
        accepted++;
      end else begin
        chk("rnd_no_grant", 32'(bus.req_ready), 0);
      end
      if (busy && (cyc_n - acc_cyc) < 2) begin
        chk("rnd_early", 32'(bus.rsp_valid), 0);
      end else if (bus.rsp_valid) begin
        chk("rnd_pending", 32'(exp_q.size()), 1);
        if (exp_q.size() != 0) begin
          chk("rnd_rsp", 32'(rsp_obs()), 32'(exp_q[0]));
          if (!prev_hold) chk("rnd_latency", 32'(cyc_n - acc_cyc), 2);
          if (bus.rsp_ready) begin
            void'(exp_q.pop_front());
            busy = 1'b0;
            served++;
          end
        end
      end
      prev_hold = bus.rsp_valid && !bus.rsp_ready;
      cyc();
    end
    bus.req_valid = '0;
    chk("rnd_all_issued", 32'(accepted >= N_OPS), 1);
    chk("rnd_drained", 32'(exp_q.size()), 0);
    chk("rnd_served", 32'(served), 32'(accepted));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
